// File: rtl/main_memory_pkg.sv
// Shared types and constants for the main_memory backing store.
package main_memory_pkg;

  localparam int unsigned MEM_ADDR_W  = 12;
  localparam int unsigned MEM_DATA_W  = 8;
  localparam int unsigned MEM_LATENCY = 3;

  // Width of the access-latency countdown; covers LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Countdown start value so the commit lands exactly LATENCY edges after accept.
  function automatic logic [CNT_W-1:0] cnt_init(int unsigned latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; kept standalone so a vendor
// macro can replace it without touching the controller.
module mem_array
  import main_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first: rdata shows the pre-write contents on a write edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency backing-store slave: accepts one granted request at a time and
// returns a one-cycle ack (plus read data) LATENCY cycles after the accept.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              gnt_arb,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata
);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] arr_rdata;
  logic              accept;
  logic              commit;
  logic              arr_we;
  logic              read_resp;

  assign accept    = (state_q == IDLE) && mem_req && gnt_arb;
  assign commit    = (state_q == WAIT) && (cnt_q == '0);
  assign arr_we    = commit && (rw_q == RW_WRITE);
  assign read_resp = (state_q == RESP) && (rw_q == RW_READ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = cnt_init(LATENCY);
        end
      end
      WAIT: begin
        if (commit) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are only sampled on the accept edge; inputs may move afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rw_q    <= mem_rw;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // The RAM re-reads every cycle, so its output is latched here after a read ack
  // to hold mem_rdata until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (read_resp) begin
      rdata_q <= arr_rdata;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign mem_busy  = (state_q != IDLE);
  assign mem_ack   = (state_q == RESP);
  assign mem_rdata = read_resp ? arr_rdata : rdata_q;

endmodule

// File: tb/tb_main_memory.sv
// Drives a LATENCY=3 and a LATENCY=1 main_memory with identical stimulus and
// compares both against a timing-rule reference model every cycle.
module tb_main_memory;
  import main_memory_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned NM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req = 1'b0;
  logic          gnt_arb = 1'b0;
  logic          mem_rw = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [NM-1:0] busy;
  logic [NM-1:0] ack;
  logic [DW-1:0] rdata [NM];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  main_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .gnt_arb   (gnt_arb),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_busy  (busy[0]),
    .mem_ack   (ack[0]),
    .mem_rdata (rdata[0])
  );

  main_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut_lat1 (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .gnt_arb   (gnt_arb),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_busy  (busy[1]),
    .mem_ack   (ack[1]),
    .mem_rdata (rdata[1])
  );

  // Reference model: each transaction is an accept edge number; everything else
  // follows from "commit at accept+L, ack after that edge, idle one edge later".
  longint        edge_n = 0;
  bit            m_inflight [NM];
  longint        m_acc [NM];
  bit            m_rw [NM];
  logic [AW-1:0] m_addr [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [DW-1:0] m_rdata [NM];
  bit            m_rdata_known [NM];
  logic [DW-1:0] m_mem [int];

  function automatic longint lat_of(int m);
    return (m == 0) ? 64'd3 : 64'd1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      m_inflight[m]    = 1'b0;
      m_rdata[m]       = '0;
      m_rdata_known[m] = 1'b1;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int m = 0; m < NM; m++) begin
      int key;
      key = m * 4096 + int'(m_addr[m]);
      if (m_inflight[m]) begin
        if (edge_n == m_acc[m] + lat_of(m)) begin
          if (m_rw[m]) begin
            m_mem[key] = m_wdata[m];
          end else if (m_mem.exists(key)) begin
            m_rdata[m]       = m_mem[key];
            m_rdata_known[m] = 1'b1;
          end else begin
            m_rdata_known[m] = 1'b0;
          end
        end else if (edge_n == m_acc[m] + lat_of(m) + 1) begin
          m_inflight[m] = 1'b0;
        end
      end else if (mem_req && gnt_arb) begin
        m_inflight[m] = 1'b1;
        m_acc[m]      = edge_n;
        m_rw[m]       = mem_rw;
        m_addr[m]     = mem_addr;
        m_wdata[m]    = mem_wdata;
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < NM; m++) begin
      check_eq($sformatf("busy%0d", m), 32'(busy[m]), 32'(m_inflight[m]));
      check_eq($sformatf("ack%0d", m), 32'(ack[m]),
               32'(m_inflight[m] && (edge_n == m_acc[m] + lat_of(m))));
      if (m_rdata_known[m]) begin
        check_eq($sformatf("rdata%0d", m), 32'(rdata[m]), 32'(m_rdata[m]));
      end
    end
  endtask

  task automatic step(input bit req, input bit gnt, input bit rw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    @(negedge clk);
    rst       = 1'b0;
    mem_req   = req;
    gnt_arb   = gnt;
    mem_rw    = rw;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, RW_READ, '0, '0);
  endtask

  // Reset is raised between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    mem_req = 1'b0;
    gnt_arb = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  // One transaction on the LATENCY=3 instance: returns edges from accept to ack.
  task automatic xact0(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lat, output logic [DW-1:0] rd);
    step(1'b1, 1'b1, rw, a, d);
    lat = 0;
    rd  = 'x;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, RW_READ, '0, '0);
      lat++;
      if (ack[0]) begin
        rd = rdata[0];
        break;
      end
    end
    idle(1);
  endtask

  initial begin
    int            lat;
    logic [DW-1:0] rd;
    longint        e_ack [2];
    logic [DW-1:0] d_ack [2];
    int            seen;
    logic [AW-1:0] pool [8];

    model_reset();
    apply_reset();

    // Quiet after reset
    idle(20);
    check_eq("idle_rdata", 32'(rdata[0]), 32'h00);

    // Write then read back
    xact0(RW_WRITE, 12'h123, 8'hA5, lat, rd);
    check_eq("wr_latency", 32'(lat), 32'd3);
    xact0(RW_READ, 12'h123, 8'h00, lat, rd);
    check_eq("rd_latency", 32'(lat), 32'd3);
    check_eq("rd_a5", 32'(rd), 32'hA5);

    // Request without grant is ignored
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, RW_READ, 12'h123, '0);
    check_eq("nogrant_busy", 32'(busy[0]), 32'd0);
    step(1'b1, 1'b1, RW_READ, 12'h123, '0);
    check_eq("grant_accept", 32'(busy[0]), 32'd1);
    idle(6);

    // Held request: back-to-back reads, new address driven during WAIT
    xact0(RW_WRITE, 12'h000, 8'h11, lat, rd);
    xact0(RW_WRITE, 12'hFFF, 8'hEE, lat, rd);
    idle(4);
    step(1'b1, 1'b1, RW_READ, 12'h000, '0);
    seen = 0;
    for (int i = 0; i < 14 && seen < 2; i++) begin
      step(1'b1, 1'b1, RW_READ, 12'hFFF, '0);
      if (ack[0]) begin
        e_ack[seen] = edge_n;
        d_ack[seen] = rdata[0];
        seen++;
      end
    end
    check_eq("held_ack_count", 32'(seen), 32'd2);
    check_eq("held_spacing", 32'(e_ack[1] - e_ack[0]), 32'd5);
    check_eq("held_first", 32'(d_ack[0]), 32'h11);
    check_eq("held_second", 32'(d_ack[1]), 32'hEE);
    idle(6);

    // Reset during WAIT drops the write
    step(1'b1, 1'b1, RW_WRITE, 12'h010, 8'h3C);
    idle(1);
    apply_reset();
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_rdata", 32'(rdata[0]), 32'h00);
    idle(4);
    xact0(RW_WRITE, 12'h010, 8'h00, lat, rd);
    xact0(RW_READ, 12'h010, 8'h00, lat, rd);
    check_eq("rst_lost_wr", 32'(rd), 32'h00);

    // LATENCY=1 instance: held reads, acks three cycles apart
    idle(6);
    seen = 0;
    for (int i = 0; i < 12 && seen < 2; i++) begin
      step(1'b1, 1'b1, RW_READ, 12'h000, '0);
      if (ack[1]) begin
        e_ack[seen] = edge_n;
        d_ack[seen] = rdata[1];
        seen++;
      end
    end
    check_eq("lat1_ack_count", 32'(seen), 32'd2);
    check_eq("lat1_spacing", 32'(e_ack[1] - e_ack[0]), 32'd3);
    check_eq("lat1_data", 32'(d_ack[0]), 32'h11);
    idle(6);

    // Randomized traffic over a small address pool
    pool[0] = 12'h000;
    pool[1] = 12'hFFF;
    pool[2] = 12'h123;
    pool[3] = 12'h010;
    for (int i = 4; i < 8; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199) == 0) begin
        apply_reset();
      end else begin
        step(($urandom_range(9) < 7), ($urandom_range(9) < 7), 1'($urandom),
             pool[$urandom_range(7)], DW'($urandom));
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
